parity_check_mealy: RTL and testbench
=====================================

# parity_check_mealy

Serial running-parity checker built as a two-state Mealy machine. It samples one input bit per clock and drives a combinational output. The output reports whether the count of 1s seen since reset, including the bit currently on the input, is odd. It sits directly on a single-bit serial stream as a leaf block, with no handshake.

## Interface

One clock; reset is synchronous and active-high.

Parameters:
- None.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous active-high reset
- x  input  1  serial data bit, sampled at each rising edge of clk
- z  output  1  Mealy parity output; 1 = odd number of 1s in (bits accepted since reset + current x)

## Operation

- States: EVEN (even count of accepted 1s; the reset state) and ODD (odd count).
- Next-state logic:
  - EVEN with x=0 stays EVEN; EVEN with x=1 goes to ODD.
  - ODD with x=0 stays ODD; ODD with x=1 goes to EVEN.
  - Equivalently, the state toggles whenever x=1.
- Output logic is combinational from the current state and x:
  - EVEN: z = x.
  - ODD: z = ~x.
  - Equivalently, z = (state==ODD) XOR x.
- Reset:
  - rst=1 at a rising edge forces the state to EVEN, regardless of x.
  - While rst=1, z is forced to 0 combinationally, so the output is defined even before the first clock edge.
- Reset mid-stream discards all accumulated parity. The first edge after rst falls counts only the bits from that point.
- Illegal or unknown state encodings recover to EVEN at the next rising edge (default branch).

## Timing

- State latency: one clock. A bit present at rising edge N affects the state from edge N onward.
- Output latency: zero cycles. z follows x combinationally within the same cycle, so a mid-cycle change on x changes z immediately. There is deliberately no output register.
- Only the value of x at the rising edge is accumulated. Glitches or pulses between edges change z transiently but not the state.
- rst is sampled only at rising edges. Its effect on z (forcing 0) is combinational.
- No enable, valid or ready signals: every rising edge with rst=0 accepts a bit.

## Structure

- Shared package parity_pkg:
  - state typedef enum logic {EVEN=1'b0, ODD=1'b1}.
  - Reset-state constant equal to EVEN.
- One always_ff block for the state register with synchronous reset.
- One always_comb block for next state and z.
- No sub-module. The datapath is a single flip-flop plus XOR, so splitting adds nothing.

## Test plan

- Reset: hold rst=1 with x=0 and x=1 for two edges -> z=0 throughout; state=EVEN after release.
- Single 1: after reset, apply x=1 for one cycle, then x=0 -> z=1 during the x=1 cycle; z=1 on following x=0 cycles (state ODD).
- Stream 1,0,1,0: with one bit per cycle -> z sequence 1,1,0,0; final state EVEN.
- Mid-cycle change: in state ODD, drop x from 1 to 0 between edges -> z toggles 0->1 immediately, and state is unchanged until the next edge.
- Sub-cycle pulse: an x=1 pulse that lies wholly between two edges -> z pulses, but the state is unchanged after the next edge.
- Reset mid-stream: reach ODD, assert rst for one edge with x=1 -> state EVEN, z=0 during reset; after release x=1 -> z=1.

Source files
------------

// File: rtl/parity_check_mealy_pkg.sv
// parity_pkg: shared types and constants for the serial running-parity checker.
//   state_t     : EVEN (even count of accepted 1s) / ODD (odd count)
//   RESET_STATE : state loaded by a synchronous reset
package parity_pkg;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = EVEN;

endpackage : parity_pkg

// File: rtl/parity_check_mealy_if.sv
// parity_check_mealy_if: bundles the single-bit serial stream and its parity
// result so a stream source and the checker can be wired as a unit.
//   x : serial data bit (driven by the source)
//   z : Mealy parity output (driven by the checker)
// There is no handshake. Every rising clock edge accepts one bit.
interface parity_check_mealy_if;

  logic x;
  logic z;

  // Stream source side
  modport master (
    output x,
    input  z
  );

  // Checker side
  modport slave (
    input  x,
    output z
  );

endinterface : parity_check_mealy_if

// File: rtl/parity_check_mealy.sv
// parity_check_mealy: two-state Mealy machine reporting running parity.
// z = 1 when the number of 1s accepted since reset, counting the bit
// currently on x, is odd. z is combinational, so it follows x within the
// cycle. Only the value of x at a rising edge updates the state.
//   clk : system clock, rising-edge state updates
//   rst : synchronous active-high reset; also forces z low combinationally
//   x   : serial data bit
//   z   : parity output
module parity_check_mealy
  import parity_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic z
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = RESET_STATE;
    z       = 1'b0;
    case (state_q)
      EVEN: begin
        state_d = x ? ODD : EVEN;
        z       = x;
      end
      ODD: begin
        state_d = x ? EVEN : ODD;
        z       = ~x;
      end
      // Unknown encodings fall back to EVEN at the next edge.
      default: begin
        state_d = RESET_STATE;
        z       = 1'b0;
      end
    endcase
    // Keeps z defined during reset, even before the first clock edge.
    if (rst) begin
      z = 1'b0;
    end
  end

endmodule : parity_check_mealy

// File: tb/tb_parity_check_mealy.sv
// tb_parity_check_mealy: directed self-checking bench for parity_check_mealy.
// Inputs change 2 ns after a rising edge and z is sampled 1 ns later. The
// state is observed through z with x=0 (z=0 means EVEN, z=1 means ODD).
module tb_parity_check_mealy;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  parity_check_mealy_if bus ();

  parity_check_mealy dut (
    .clk (clk),
    .rst (rst),
    .x   (bus.x),
    .z   (bus.z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: z=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_chk(input string tag, input logic xv, input logic exp);
    bus.x = xv;
    #1;
    check(tag, bus.z, exp);
  endtask

  logic [3:0] stream_x;
  logic [3:0] stream_z;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.x    = 1'b0;

    // Reset: z held at 0 before and across edges, for both x values
    drive_chk("rst_pre_edge_x0", 1'b0, 1'b0);
    drive_chk("rst_pre_edge_x1", 1'b1, 1'b0);
    tick();
    drive_chk("rst_edge1_x1", 1'b1, 1'b0);
    tick();
    drive_chk("rst_edge2_x0", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive_chk("after_rst_even", 1'b0, 1'b0);

    // Single 1, then zeros: state ODD persists
    drive_chk("single_one_x1", 1'b1, 1'b1);
    tick();
    drive_chk("single_one_odd_a", 1'b0, 1'b1);
    tick();
    drive_chk("single_one_odd_b", 1'b0, 1'b1);

    // Back to EVEN via reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_chk("rst_to_even", 1'b0, 1'b0);

    // Stream 1,0,1,0 -> z 1,1,0,0 (bit 3 is applied first)
    stream_x = 4'b1010;
    stream_z = 4'b1100;
    for (int i = 3; i >= 0; i--) begin
      drive_chk($sformatf("stream_bit%0d", 3 - i), stream_x[i], stream_z[i]);
      tick();
    end
    drive_chk("stream_final_even", 1'b0, 1'b0);

    // Mid-cycle change in ODD
    bus.x = 1'b1;
    tick();
    drive_chk("mid_odd_x1", 1'b1, 1'b0);
    drive_chk("mid_odd_x0", 1'b0, 1'b1);
    tick();
    drive_chk("mid_state_kept", 1'b0, 1'b1);

    // Sub-cycle pulse in ODD: z pulses, state unchanged
    drive_chk("pulse_high", 1'b1, 1'b0);
    drive_chk("pulse_low", 1'b0, 1'b1);
    tick();
    drive_chk("pulse_state_kept", 1'b0, 1'b1);

    // Reset mid-stream from ODD with x=1
    rst = 1'b1;
    drive_chk("midrst_z0", 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    drive_chk("midrst_even", 1'b0, 1'b0);
    drive_chk("midrst_then_x1", 1'b1, 1'b1);
    tick();
    drive_chk("midrst_odd_after", 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_parity_check_mealy
